// File: rtl/avm_master_pkg.sv
// Shared types and constants for the Avalon-MM command master.
package avm_master_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RD = 2'd2,
    RSP     = 2'd3
  } state_t;

  // Read data reported when a transfer is aborted by the watchdog.
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/avm_timeout_counter.sv
// Transfer watchdog: count holds the 1-based cycle number of the current
// transfer; expired flags the LIMIT-th cycle spent waiting on the slave.
module avm_timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count;

  assign expired = run && (count == CNT_W'(LIMIT));

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= CNT_W'(1);
    end else if (run && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/avalon_mm_cmd_master.sv
// Avalon-MM initiator turning single valid/ready commands into one Avalon transfer
// and one response each. Optional watchdog: define AVM_MASTER_TIMEOUT_EN.
module avalon_mm_cmd_master
  import avm_master_pkg::*;
#(
  parameter int ADDR_W         = 2,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_address,
  input  logic [DATA_W-1:0]   cmd_writedata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_readdata,
  output logic                rsp_error,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid,
  output logic [1:0]          dbg_state
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  // Handshakes: a command transfers on the edge where cmd_valid && cmd_ready;
  // a response transfers on the edge where rsp_valid && rsp_ready. rsp_* is
  // held stable while rsp_valid is high and rsp_ready is low.

  state_t              state, state_n;
  logic                accept;
  logic                cmd_ready_n, rsp_valid_n, rsp_error_n;
  logic                avm_read_n, avm_write_n;
  logic [ADDR_W-1:0]   avm_address_n;
  logic [DATA_W-1:0]   avm_writedata_n, rsp_readdata_n;

  assign accept         = (state == IDLE) && cmd_valid && cmd_ready;
  assign avm_byteenable = '1;
  assign dbg_state      = state;

`ifdef AVM_MASTER_TIMEOUT_EN
  logic timeout_hit;

  avm_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .run     ((state == REQ) || (state == WAIT_RD)),
    .expired (timeout_hit)
  );
`endif

  always_comb begin
    state_n         = state;
    avm_read_n      = avm_read;
    avm_write_n     = avm_write;
    avm_address_n   = avm_address;
    avm_writedata_n = avm_writedata;
    rsp_valid_n     = rsp_valid;
    rsp_readdata_n  = rsp_readdata;
    rsp_error_n     = rsp_error;

    case (state)
      IDLE: begin
        if (accept) begin
          state_n         = REQ;
          avm_address_n   = cmd_address;
          avm_writedata_n = cmd_writedata;
          avm_read_n      = !cmd_write;
          avm_write_n     = cmd_write;
        end
      end
      REQ: begin
        if (!avm_waitrequest) begin
          avm_read_n  = 1'b0;
          avm_write_n = 1'b0;
          if (avm_write) begin
            state_n        = RSP;
            rsp_valid_n    = 1'b1;
            rsp_readdata_n = '0;
            rsp_error_n    = 1'b0;
          end else begin
            state_n = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (avm_readdatavalid) begin
          state_n        = RSP;
          rsp_valid_n    = 1'b1;
          rsp_readdata_n = avm_readdata;
          rsp_error_n    = 1'b0;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_n     = IDLE;
          rsp_valid_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase

`ifdef AVM_MASTER_TIMEOUT_EN
    // A transfer that completes in its last allowed cycle is not aborted.
    if (timeout_hit && (state_n != RSP)) begin
      state_n        = RSP;
      rsp_valid_n    = 1'b1;
      rsp_readdata_n = DATA_W'(TIMEOUT_DATA);
      rsp_error_n    = 1'b1;
      avm_read_n     = 1'b0;
      avm_write_n    = 1'b0;
    end
`endif

    cmd_ready_n = (state_n == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_address   <= '0;
      avm_writedata <= '0;
      rsp_valid     <= 1'b0;
      rsp_readdata  <= '0;
      rsp_error     <= 1'b0;
    end else begin
      state         <= state_n;
      cmd_ready     <= cmd_ready_n;
      avm_read      <= avm_read_n;
      avm_write     <= avm_write_n;
      avm_address   <= avm_address_n;
      avm_writedata <= avm_writedata_n;
      rsp_valid     <= rsp_valid_n;
      rsp_readdata  <= rsp_readdata_n;
      rsp_error     <= rsp_error_n;
    end
  end

endmodule
